sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
Serial-in/parallel-out deserializer that sits directly upstream of the parallel-load register stage. It assembles WIDTH serial bits into a word and presents that word on a valid/ready output port. A one-word output holding register decouples the serial stream from the consumer. A sticky overrun flag reports words that were dropped because the consumer stalled.

Parameters:
WIDTH, 4, data bits per word (>=2)
MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0]

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous active-high reset
serial_in  input  1  serial data bit
serial_valid  input  1  serial_in is sampled on this cycle
sync  input  1  frame start; the bit sampled this cycle is bit 0 of a new word
word_out  output  WIDTH  assembled word, stable while word_valid=1
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts the word when word_valid=1
bit_cnt  output  clog2(WIDTH+1)  bits collected for the current word
overrun  output  1  sticky: a completed word was dropped
overrun_clr  input  1  clears overrun

Behaviour:
- Reset (clk edge with rst=1): shift register=0, bit_cnt=0, word_out=0, word_valid=0, overrun=0. Reset overrides every other input.
- Reset mid-word discards the partial word. A pending word_out is discarded and word_valid drops.
- Bit accept: each cycle with serial_valid=1 shifts serial_in into the shift register and increments bit_cnt.
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Cycles with serial_valid=0 hold all state. The gap between bits may be any length.
- sync=1 with serial_valid=1: bit_cnt restarts and this bit is counted as bit 0 (bit_cnt becomes 1). Any partial word is discarded without setting overrun.
- sync=1 with serial_valid=0: bit_cnt=0, partial word discarded.
- Word complete: occurs when the WIDTH-th bit is accepted (bit_cnt==WIDTH-1 and serial_valid=1, sync=0). On the same edge bit_cnt returns to 0. The completed word goes to the output stage.
- Output load: the completed word is written to word_out and word_valid=1 on that edge if either:
  - word_valid=0, or
  - word_valid=1 and word_ready=1 (consume and reload in the same cycle, no bubble).
- Latency: word_valid asserts on the cycle after the last bit's sampling edge, i.e. 1 cycle.
- Consume: word_valid=1 and word_ready=1 with no new completion clears word_valid next cycle. word_out holds its last value.
- Overrun: a completion while word_valid=1 and word_ready=0 drops the new word. word_out is unchanged and overrun sets to 1.
- overrun_clr=1 clears overrun next cycle. If an overrun event occurs in the same cycle, set wins.
- word_ready is ignored when word_valid=0.
- Full throughput: one word per WIDTH cycles with serial_valid held high and word_ready high.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit, so bit_cnt counts to WIDTH+1.
  - Completion happens on the parity bit; the parity bit is not stored in word_out.
  - Added output port parity_err (1 bit) is updated with word_out on each load: 1 if XOR(data bits, parity bit)=1.
  - parity_err resets to 0.
  - Overrun and sync rules apply identically to the extended frame.
- Not defined: no parity bit, no parity_err port, frame is exactly WIDTH bits.

Test Plan:
- rst=1 mid-word (bit_cnt=2) with word_valid=1 -> next cycle bit_cnt=0, word_valid=0, word_out=0, overrun=0.
- WIDTH=4, MSB_FIRST=1, sync on the first bit, serial 1,0,1,1 on consecutive cycles, word_ready=1 -> word_out=4'b1011, word_valid=1 for exactly 1 cycle, 1 cycle after the last bit. With MSB_FIRST=0 the same stream gives 4'b1101.
- Continuous stream 1011,0110,1111 with word_ready=1 -> three back-to-back words with no missing word and no overrun.
- word_ready=0, two words 1010 then 0101 -> word_out stays 1010 and overrun=1. Then word_ready=1 for one cycle -> word_valid=0. Then overrun_clr -> overrun=0.
- Bits 1,1 then sync with bit 0, then 0,1,1 -> word_out=4'b0011, overrun stays 0.
- SIPO_PARITY_EN, data 1011 with parity 1 -> parity_err=0. Same data with parity 0 -> parity_err=1, word_out=1011.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with a one-word valid/ready holding stage and sticky overrun.
// Define SIPO_PARITY_EN to append an even-parity bit to every frame and expose parity_err.
module sipo_deser #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       serial_in,
    input  logic                       serial_valid,
    input  logic                       sync,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun,
`ifdef SIPO_PARITY_EN
    output logic                       parity_err,
`endif
    input  logic                       overrun_clr
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shift_c;
    logic [WIDTH-1:0] sreg_fresh_c;
    logic [WIDTH-1:0] word_c;
    logic             complete_c;
    logic             load_c;
    logic             drop_c;
`ifdef SIPO_PARITY_EN
    logic             par_acc;
    logic             perr_c;
`endif

    // Shift/assembly datapath and output-stage decisions
    always_comb begin
        sreg_shift_c = sreg;
        sreg_fresh_c = '0;
        if (MSB_FIRST != 0) begin
            sreg_shift_c = {sreg[WIDTH-2:0], serial_in};
            sreg_fresh_c = {{(WIDTH-1){1'b0}}, serial_in};
        end else begin
            sreg_shift_c = {serial_in, sreg[WIDTH-1:1]};
            sreg_fresh_c = {serial_in, {(WIDTH-1){1'b0}}};
        end

        complete_c = serial_valid && !sync && (bit_cnt == LAST_IDX);
`ifdef SIPO_PARITY_EN
        // The parity bit completes the frame but never enters the data word
        word_c = sreg;
        perr_c = par_acc ^ serial_in;
`else
        word_c = sreg_shift_c;
`endif
        load_c = complete_c && (!word_valid || word_ready);
        drop_c = complete_c && word_valid && !word_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            bit_cnt    <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // Serial capture; sync restarts the frame, with or without a bit
            if (serial_valid) begin
                if (sync) begin
                    sreg    <= sreg_fresh_c;
                    bit_cnt <= CNT_W'(1);
`ifdef SIPO_PARITY_EN
                    par_acc <= serial_in;
`endif
                end else if (complete_c) begin
                    sreg    <= '0;
                    bit_cnt <= '0;
`ifdef SIPO_PARITY_EN
                    par_acc <= 1'b0;
`endif
                end else begin
                    sreg    <= sreg_shift_c;
                    bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef SIPO_PARITY_EN
                    par_acc <= par_acc ^ serial_in;
`endif
                end
            end else if (sync) begin
                sreg    <= '0;
                bit_cnt <= '0;
`ifdef SIPO_PARITY_EN
                par_acc <= 1'b0;
`endif
            end

            // Holding register: reload in the consume cycle without a bubble
            if (load_c) begin
                word_out   <= word_c;
                word_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err <= perr_c;
`endif
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            if (drop_c) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: MSB-first instance checked by queue, LSB-first instance spot-checked.
// Build with SIPO_PARITY_EN defined to exercise the parity frame.
module tb_sipo_deser;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic          serial_valid;
    logic          sync;
    logic          word_ready;
    logic          overrun_clr;
    logic [WIDTH-1:0] word_out, word_out_l;
    logic          word_valid, word_valid_l;
    logic [CW-1:0] bit_cnt, bit_cnt_l;
    logic          overrun, overrun_l;
    logic          parity_err, parity_err_l;

    int n_checks = 0;
    int n_errors = 0;
    int gap_max  = 0;
    logic [WIDTH:0] exp_q[$];
    logic prev_v  = 1'b0;
    logic prev_hs = 1'b0;

    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .bit_cnt(bit_cnt), .overrun(overrun),
`ifdef SIPO_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun_clr(overrun_clr)
    );

    sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
        .sync(sync), .word_out(word_out_l), .word_valid(word_valid_l),
        .word_ready(word_ready), .bit_cnt(bit_cnt_l), .overrun(overrun_l),
`ifdef SIPO_PARITY_EN
        .parity_err(parity_err_l),
`endif
        .overrun_clr(overrun_clr)
    );

`ifndef SIPO_PARITY_EN
    assign parity_err   = 1'b0;
    assign parity_err_l = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        serial_in    = b;
        sync         = s;
        serial_valid = 1'b1;
        tick();
        serial_valid = 1'b0;
        sync         = 1'b0;
        serial_in    = 1'b0;
        repeat ($urandom_range(gap_max, 0)) tick();
    endtask

    // Bits go out w[3] first; parity bit (if enabled) is even parity, optionally corrupted
    task automatic send_word(input logic [WIDTH-1:0] w, input logic s, input logic inj);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], s && (i == WIDTH - 1));
        if (PAR_EN) send_bit((^w) ^ inj, 1'b0);
    endtask

    task automatic expect_word(input logic [WIDTH-1:0] w, input logic inj);
        exp_q.push_back({PAR_EN ? inj : 1'b0, w});
    endtask

    // A new word is visible when valid rises or reloads right after a handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_v  <= 1'b0;
            prev_hs <= 1'b0;
        end else begin
            if (word_valid && (!prev_v || prev_hs)) begin
                if (exp_q.size() == 0) chk("sb_unexpected", {27'd0, parity_err, word_out}, 32'hFFFF_FFFF);
                else chk("sb_word", {27'd0, parity_err, word_out}, {27'd0, exp_q.pop_front()});
            end
            prev_v  <= word_valid;
            prev_hs <= word_valid && word_ready;
        end
    end

    initial begin
        logic [WIDTH-1:0] w;
        rst = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; sync = 1'b0;
        word_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_bit_cnt", 32'(bit_cnt), 0);
        chk("rst_valid", 32'(word_valid), 0);
        chk("rst_word", 32'(word_out), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // Single word, both bit orders, one-cycle valid pulse
        expect_word(4'b1011, 1'b0);
        send_word(4'b1011, 1'b1, 1'b0);
        chk("lat_valid", 32'(word_valid), 1);
        chk("msb_word", 32'(word_out), 32'b1011);
        chk("lsb_valid", 32'(word_valid_l), 1);
        chk("lsb_word", 32'(word_out_l), 32'b1101);
        tick();
        chk("pulse_valid", 32'(word_valid), 0);

        // Back-to-back stream, no gaps
        foreach (exp_q[i]) ;
        expect_word(4'b1011, 1'b0); expect_word(4'b0110, 1'b0); expect_word(4'b1111, 1'b0);
        send_word(4'b1011, 1'b1, 1'b0);
        send_word(4'b0110, 1'b0, 1'b0);
        send_word(4'b1111, 1'b0, 1'b0);
        chk("stream_overrun", 32'(overrun), 0);
        chk("stream_bit_cnt", 32'(bit_cnt), 0);
        tick();

        // Overrun: second word dropped while stalled
        word_ready = 1'b0;
        expect_word(4'b1010, 1'b0);
        send_word(4'b1010, 1'b0, 1'b0);
        send_word(4'b0101, 1'b0, 1'b0);
        chk("ovr_word", 32'(word_out), 32'b1010);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_valid", 32'(word_valid), 1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("ovr_drain", 32'(word_valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);

        // Set beats clear when both happen on the same edge
        expect_word(4'b0110, 1'b0);
        send_word(4'b0110, 1'b0, 1'b0);
        overrun_clr = 1'b1;
        send_word(4'b1110, 1'b0, 1'b0);
        overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 1);
        chk("ovr_set_word", 32'(word_out), 32'b0110);
        overrun_clr = 1'b1; word_ready = 1'b1;
        tick();
        overrun_clr = 1'b0;

        // Resync mid-word discards the partial bits
        w = 4'b0011;
        expect_word(w, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("sync_bit_cnt", 32'(bit_cnt), 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        if (PAR_EN) send_bit(^w, 1'b0);
        chk("sync_word", 32'(word_out), 32'b0011);
        chk("sync_overrun", 32'(overrun), 0);
        tick();

        // Reset mid-word with a pending word
        word_ready = 1'b0;
        expect_word(4'b1100, 1'b0);
        send_word(4'b1100, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("pre_rst_cnt", 32'(bit_cnt), 2);
        chk("pre_rst_valid", 32'(word_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cnt", 32'(bit_cnt), 0);
        chk("mid_rst_valid", 32'(word_valid), 0);
        chk("mid_rst_word", 32'(word_out), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        word_ready = 1'b1;
        expect_word(4'b1001, 1'b0);
        send_word(4'b1001, 1'b0, 1'b0);
        tick();

`ifdef SIPO_PARITY_EN
        expect_word(4'b1011, 1'b0);
        send_word(4'b1011, 1'b0, 1'b0);
        chk("par_ok", 32'(parity_err), 0);
        expect_word(4'b1011, 1'b1);
        send_word(4'b1011, 1'b0, 1'b1);
        chk("par_bad", 32'(parity_err), 1);
        chk("par_bad_word", 32'(word_out), 32'b1011);
        tick();
`endif

        // Random words with random idle gaps between bits
        gap_max = 2;
        for (int k = 0; k < 8; k++) begin
            w = WIDTH'($urandom_range(15, 0));
            expect_word(w, 1'b0);
            send_word(w, 1'b0, 1'b0);
        end
        gap_max = 0;
        repeat (3) tick();
        chk("rand_overrun", 32'(overrun), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);
        chk("lsb_idle", {29'd0, overrun_l, parity_err_l, 1'b0} | 32'(bit_cnt_l), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
